mem_port_arbiter: RTL and testbench

Shares one single-ported unified memory between the pipeline's instruction-fetch requester (read-only) and its MEM-stage requester (load/store). Arbitrates with data-priority and a bounded-starvation guard for fetch. Generates per-requester stall signals that feed PC/IF_ID write-enable and pipeline freeze logic. Flags hung memory transactions with a timeout.

---
 rtl/cpu_mem_pkg.sv | 23 ++
 rtl/mem_arb_timer.sv | 27 ++
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, grant owner
// encoding and default bus widths.
package cpu_mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  function automatic arb_owner_e state_owner(input arb_state_e s);
    return (s == GNT_D) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Clearable saturating cycle counter; o_expire flags the cycle whose
// increment would bring the count to TIMEOUT.
module mem_arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] SAT  = TW'(TIMEOUT);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                        r_cnt <= '0;
    else if (i_clr)                   r_cnt <= '0;
    else if (i_en && (r_cnt != SAT))  r_cnt <= r_cnt + 1'b1;
  end

  assign o_expire = i_en & (r_cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store traffic onto one single-ported memory:
// data has priority, a streak guard bounds fetch starvation, timer aborts hangs.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STREAK_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_stall_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_stall_o,
  output logic              m_req_o,
  output logic              m_we_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_wdata_o,
  input  logic              m_ack_i,
  input  logic [DATA_W-1:0] m_rdata_i,
  output logic              err_o
);

  localparam int SW = $clog2(STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_SAT = SW'(STREAK_MAX);

  arb_state_e    r_state;
  logic [SW-1:0] r_streak;

  logic w_i_elig, w_d_elig, w_pick_d, w_in_gnt, w_expire, w_done;

  // A requester in its own ack cycle is not eligible, so it cannot be re-granted
  // on the request it is just dropping.
  assign w_i_elig = if_req_i & ~if_ack_o;
  assign w_d_elig = d_req_i  & ~d_ack_o;
  assign w_pick_d = w_d_elig & ~((r_streak == STREAK_SAT) & w_i_elig);
  assign w_in_gnt = (r_state != IDLE);
  assign w_done   = w_in_gnt & (m_ack_i | w_expire);

  assign if_stall_o = if_req_i & ~if_ack_o;
  assign d_stall_o  = d_req_i  & ~d_ack_o;

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_clr    (~w_in_gnt),
    .i_en     (w_in_gnt & ~m_ack_i),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_streak   <= '0;
      if_ack_o   <= 1'b0;
      if_rdata_o <= '0;
      d_ack_o    <= 1'b0;
      d_rdata_o  <= '0;
      m_req_o    <= 1'b0;
      m_we_o     <= 1'b0;
      m_addr_o   <= '0;
      m_wdata_o  <= '0;
      err_o      <= 1'b0;
    end else begin
      if_ack_o <= 1'b0;
      d_ack_o  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_d) begin
            r_state   <= GNT_D;
            m_req_o   <= 1'b1;
            m_we_o    <= d_we_i;
            m_addr_o  <= d_addr_i;
            m_wdata_o <= d_wdata_i;
            if (!if_req_i)                     r_streak <= '0;
            else if (r_streak != STREAK_SAT)   r_streak <= r_streak + 1'b1;
          end else if (w_i_elig) begin
            r_state   <= GNT_I;
            m_req_o   <= 1'b1;
            m_we_o    <= 1'b0;
            m_addr_o  <= if_addr_i;
            m_wdata_o <= '0;
            r_streak  <= '0;
          end
        end
        GNT_I, GNT_D: begin
          if (w_done) begin
            r_state <= IDLE;
            m_req_o <= 1'b0;
            if (!m_ack_i) err_o <= 1'b1;
            if (state_owner(r_state) == OWN_I) begin
              if_ack_o   <= 1'b1;
              if_rdata_o <= m_ack_i ? m_rdata_i : '0;
            end else begin
              d_ack_o <= 1'b1;
              // Aborts zero the load data; a completed store keeps the old value.
              if (!m_ack_i)     d_rdata_o <= '0;
              else if (!m_we_o) d_rdata_o <= m_rdata_i;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, collision, streak guard, store,
// timeout and asynchronous reset during a grant.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        if_stall_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_ack_o;
  logic [31:0] d_rdata_o;
  logic        d_stall_o;
  logic        m_req_o;
  logic        m_we_o;
  logic [31:0] m_addr_o;
  logic [31:0] m_wdata_o;
  logic        m_ack_i;
  logic [31:0] m_rdata_i;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STREAK_MAX(4), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o),
    .if_rdata_o(if_rdata_o), .if_stall_o(if_stall_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o), .d_stall_o(d_stall_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_ack_i(m_ack_i), .m_rdata_i(m_rdata_i), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mem_ack(input logic [31:0] data);
    m_ack_i   = 1'b1;
    m_rdata_i = data;
    step();
    m_ack_i   = 1'b0;
    m_rdata_i = '0;
  endtask

  initial begin
    rst_i = 1'b1; if_req_i = 0; if_addr_i = 0; d_req_i = 0; d_we_i = 0;
    d_addr_i = 0; d_wdata_i = 0; m_ack_i = 0; m_rdata_i = 0;
    #2;
    chk("rst_mreq", m_req_o, 0);
    chk("rst_acks", {if_ack_o, d_ack_o}, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rdata", {if_rdata_o, d_rdata_o}, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    step();

    // single fetch
    if_req_i = 1; if_addr_i = 32'h40;
    #1;
    chk("f_stall_pre", if_stall_o, 1);
    chk("f_mreq_pre", m_req_o, 0);
    step();
    chk("f_mreq", m_req_o, 1);
    chk("f_addr", m_addr_o, 32'h40);
    chk("f_we_wd", {m_we_o, m_wdata_o}, 0);
    chk("f_stall_gnt", if_stall_o, 1);
    step();
    chk("f_hold", m_req_o, 1);
    mem_ack(32'h8C220004);
    chk("f_ack", if_ack_o, 1);
    chk("f_rdata", if_rdata_o, 32'h8C220004);
    chk("f_mreq_clr", m_req_o, 0);
    chk("f_stall_ack", if_stall_o, 0);
    if_req_i = 0;
    step();
    chk("f_ack_once", if_ack_o, 0);
    chk("f_no_regnt", m_req_o, 0);

    // collision: data first, fetch in the data ack cycle
    if_req_i = 1; if_addr_i = 32'h44; d_req_i = 1; d_we_i = 0; d_addr_i = 32'h100;
    step();
    chk("c_addr_d", m_addr_o, 32'h100);
    chk("c_stalls", {if_stall_o, d_stall_o}, 2'b11);
    mem_ack(32'h11112222);
    chk("c_dack", d_ack_o, 1);
    chk("c_drdata", d_rdata_o, 32'h11112222);
    chk("c_istall_dack", if_stall_o, 1);
    d_req_i = 0;
    step();
    chk("c_addr_i", {m_req_o, m_addr_o}, {1'b1, 32'h44});
    chk("c_istall_ig", if_stall_o, 1);
    mem_ack(32'h33334444);
    chk("c_iack", {if_ack_o, if_rdata_o}, {1'b1, 32'h33334444});
    if_req_i = 0;
    step();

    // streak guard: fetch briefly withdraws in each data ack cycle
    if_addr_i = 32'h80; d_req_i = 1; d_we_i = 0;
    for (int k = 0; k < 4; k++) begin
      if_req_i = 1; d_addr_i = 32'h200 + 32'(4 * k);
      step();
      chk("s_dgnt", m_addr_o, 32'h200 + 32'(4 * k));
      mem_ack(32'(k));
      if_req_i = 0;
      step();
      chk("s_idle", m_req_o, 0);
    end
    if_req_i = 1; d_addr_i = 32'h300;
    step();
    chk("s_fetch_wins", {m_addr_o, m_we_o}, {32'h80, 1'b0});
    chk("s_dstall", d_stall_o, 1);
    mem_ack(32'h55);
    chk("s_iack", if_ack_o, 1);
    if_req_i = 0;
    step();
    chk("s_d_after", m_addr_o, 32'h300);
    mem_ack(32'h66);
    d_req_i = 0;
    step();
    if_req_i = 1; if_addr_i = 32'h84; d_req_i = 1; d_addr_i = 32'h304;
    step();
    chk("s_reset_streak", m_addr_o, 32'h304);
    mem_ack(32'h77);
    d_req_i = 0;
    step();
    chk("s_f_after", m_addr_o, 32'h84);
    mem_ack(32'h88);
    if_req_i = 0;
    step();

    // store: fields held, d_rdata unchanged
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h20; d_wdata_i = 32'hDEADBEEF;
    step();
    chk("w_fields", {m_we_o, m_addr_o, m_wdata_o}, {1'b1, 32'h20, 32'hDEADBEEF});
    d_wdata_i = 0; d_we_i = 0;
    step();
    chk("w_hold", {m_req_o, m_we_o, m_wdata_o}, {2'b11, 32'hDEADBEEF});
    mem_ack(32'hAAAAAAAA);
    chk("w_ack", d_ack_o, 1);
    chk("w_rdata_kept", d_rdata_o, 32'h77);
    d_req_i = 0;
    step();

    // timeout after 8 grant cycles
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h50;
    step();
    chk("t_mreq_c1", m_req_o, 1);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("t_mreq_hold", m_req_o, 1);
    end
    chk("t_err_pre", err_o, 0);
    step();
    chk("t_drop", m_req_o, 0);
    chk("t_dack", {d_ack_o, d_rdata_o}, {1'b1, 32'h0});
    chk("t_err", err_o, 1);
    d_req_i = 0;
    m_ack_i = 1; m_rdata_i = 32'hFFFF;
    step();
    m_ack_i = 0; m_rdata_i = 0;
    chk("t_late_ack", {d_ack_o, if_ack_o, m_req_o, d_rdata_o}, 0);
    step();
    chk("t_err_sticky", err_o, 1);

    // asynchronous reset during a fetch grant
    if_req_i = 1; if_addr_i = 32'h60;
    step();
    chk("r_gnt", {m_req_o, err_o}, 2'b11);
    rst_i = 1;
    #1;
    chk("r_async", {m_req_o, if_ack_o, err_o}, 0);
    step();
    rst_i = 0;
    #1;
    chk("r_idle", m_req_o, 0);
    begin : wait_regrant
      int n = 0;
      while (!m_req_o && n < 4) begin step(); n++; end
      chk("r_regrant_wait", m_req_o, 1);
      chk("r_regrant_lat", n, 1);
    end
    chk("r_addr", m_addr_o, 32'h60);
    mem_ack(32'h12345678);
    chk("r_iack", {if_ack_o, if_rdata_o}, {1'b1, 32'h12345678});
    if_req_i = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
